// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. The unit issues one instruction-memory request
// per accepted PC and keeps the PC of every request in an in-order pending
// queue. Each response is paired with its PC and written into a small
// instruction buffer that feeds decode.
//
// Request issue uses credits: a request is only made while
// (outstanding + buffer_count) < DEPTH. Every response therefore has a buffer
// slot waiting for it, and the buffer cannot overflow.
//
// A redirect flushes the buffer and the pending queue. Any responses still in
// flight are counted in drop_count and discarded when they return.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   pc              current PC from the external program counter register
//   pc_en, next_pc  load enable and load value for that PC register
//   redirect_valid  branch/jump redirect from execute, with target redirect_pc
//   imem_req/addr   request to instruction memory; imem_gnt accepts it
//   imem_rvalid     in-order response, with instruction in imem_rdata
//   id_valid        buffer head is valid; id_instr/id_pc describe it
//   id_ready        decode accepts the head entry this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_en,
    output logic [WIDTH-1:0] next_pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    input  logic             id_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // One extra bit so that sums of two counters cannot overflow.
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Advance a circular pointer over DEPTH entries. DEPTH need not be a
    // power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Counters and queue pointers
    logic [CNT_W-1:0] out_q,      out_d;       // live requests awaiting response
    logic [CNT_W-1:0] drop_q,     drop_d;      // flushed requests still in flight
    logic [CNT_W-1:0] buf_cnt_q,  buf_cnt_d;
    logic [PTR_W-1:0] pend_rd_q,  pend_rd_d;
    logic [PTR_W-1:0] pend_wr_q,  pend_wr_d;
    logic [PTR_W-1:0] buf_rd_q,   buf_rd_d;
    logic [PTR_W-1:0] buf_wr_q,   buf_wr_d;

    // Storage
    logic [WIDTH-1:0] pend_pc_q   [DEPTH];
    logic [WIDTH-1:0] buf_pc_q    [DEPTH];
    logic [WIDTH-1:0] buf_instr_q [DEPTH];

    // Handshake decodes
    logic [CNT_W:0] credit_s;     // outstanding + buffer_count
    logic [CNT_W:0] inflight_s;   // outstanding + drop_count
    logic           accept_s;
    logic           rsp_live_s;   // response that is written into the buffer
    logic           rsp_drop_s;   // response for a flushed request
    logic           rsp_redir_s;  // response that arrives together with a redirect
    logic           pop_s;

    // Request credit, response classification and buffer pop
    always_comb begin
        credit_s    = {1'b0, out_q} + {1'b0, buf_cnt_q};
        inflight_s  = {1'b0, out_q} + {1'b0, drop_q};
        imem_req    = !rst && !redirect_valid && (credit_s < DEPTH_C);
        imem_addr   = pc;
        accept_s    = imem_req && imem_gnt;
        rsp_drop_s  = imem_rvalid && !redirect_valid && (drop_q != {CNT_W{1'b0}});
        // With nothing in flight, a response is stray and is ignored.
        rsp_live_s  = imem_rvalid && !redirect_valid && (drop_q == {CNT_W{1'b0}})
                      && (out_q != {CNT_W{1'b0}});
        rsp_redir_s = imem_rvalid && redirect_valid && (inflight_s != {(CNT_W + 1){1'b0}});
        id_valid    = !rst && (buf_cnt_q != {CNT_W{1'b0}});
        pop_s       = id_valid && id_ready;
    end

    // PC update: a redirect has priority over sequential advance
    always_comb begin
        pc_en = !rst && (redirect_valid || accept_s);
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else begin
            next_pc = pc + WIDTH'(4);
        end
    end

    // Buffer head presented to decode
    always_comb begin
        id_instr = buf_instr_q[buf_rd_q];
        id_pc    = buf_pc_q[buf_rd_q];
    end

    // Next-state logic for the counters and pointers
    always_comb begin
        out_d     = out_q;
        drop_d    = drop_q;
        buf_cnt_d = buf_cnt_q;
        pend_rd_d = pend_rd_q;
        pend_wr_d = pend_wr_q;
        buf_rd_d  = buf_rd_q;
        buf_wr_d  = buf_wr_q;
        if (redirect_valid) begin
            // Flush. All requests still in flight become drops, whether they
            // were live or already flushed. This keeps back-to-back redirects
            // consistent. A response arriving in this cycle is the oldest one
            // in flight and is consumed at once.
            out_d     = {CNT_W{1'b0}};
            buf_cnt_d = {CNT_W{1'b0}};
            pend_rd_d = {PTR_W{1'b0}};
            pend_wr_d = {PTR_W{1'b0}};
            buf_rd_d  = {PTR_W{1'b0}};
            buf_wr_d  = {PTR_W{1'b0}};
            drop_d    = CNT_W'(inflight_s - (CNT_W + 1)'(rsp_redir_s));
        end else begin
            if (rsp_drop_s) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
            out_d     = out_q + CNT_W'(accept_s) - CNT_W'(rsp_live_s);
            buf_cnt_d = buf_cnt_q + CNT_W'(rsp_live_s) - CNT_W'(pop_s);
            pend_wr_d = accept_s   ? ptr_inc(pend_wr_q) : pend_wr_q;
            pend_rd_d = rsp_live_s ? ptr_inc(pend_rd_q) : pend_rd_q;
            buf_wr_d  = rsp_live_s ? ptr_inc(buf_wr_q)  : buf_wr_q;
            buf_rd_d  = pop_s      ? ptr_inc(buf_rd_q)  : buf_rd_q;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= {CNT_W{1'b0}};
            drop_q    <= {CNT_W{1'b0}};
            buf_cnt_q <= {CNT_W{1'b0}};
            pend_rd_q <= {PTR_W{1'b0}};
            pend_wr_q <= {PTR_W{1'b0}};
            buf_rd_q  <= {PTR_W{1'b0}};
            buf_wr_q  <= {PTR_W{1'b0}};
        end else begin
            out_q     <= out_d;
            drop_q    <= drop_d;
            buf_cnt_q <= buf_cnt_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
            buf_rd_q  <= buf_rd_d;
            buf_wr_q  <= buf_wr_d;
        end
    end

    // Data storage. Validity is tracked by the counters, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            pend_pc_q[pend_wr_q] <= pc;
        end
        if (rsp_live_s) begin
            buf_pc_q[buf_wr_q]    <= pend_pc_q[pend_rd_q];
            buf_instr_q[buf_wr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (WIDTH=32, DEPTH=2).
//
// Bench models
//   - PC register: loads next_pc when pc_en is high, and resets to 0x0.
//   - In-order instruction memory: responds in the cycle after a grant, with
//     instr = addr ^ 0xDEAD0000. mem_hold makes it hold back responses.
//
// Checking
//   - Expected decode entries are pushed into exp_q when a scenario starts.
//   - A monitor pops exp_q on every id_valid && id_ready handshake and
//     compares the entry against id_pc and id_instr.
//   - The main process directly checks reset behaviour, redirect, wrap-around
//     and grant counts.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_r;
    logic        pc_en;
    logic [31:0] next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        mem_hold;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          grant_cnt = 0;
    exp_t        exp_q[$];
    logic [31:0] mq[$];

    fetch_unit #(.WIDTH(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc_r),
        .pc_en          (pc_en),
        .next_pc        (next_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    // Program counter register model
    always @(posedge clk) begin
        if (rst)          pc_r <= 32'h0000_0000;
        else if (pc_load) pc_r <= pc_load_val;
        else if (pc_en)   pc_r <= next_pc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Instruction memory model: samples at negedge, drives 2 units after posedge
    initial begin : mem_model
        logic        g;
        logic        r;
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        forever begin
            @(negedge clk);
            g = imem_req && imem_gnt;
            a = imem_addr;
            r = imem_rvalid;
            if (g) grant_cnt++;
            @(posedge clk);
            #2;
            if (r) void'(mq.pop_front());
            if (g) mq.push_back(a);
            if (!mem_hold && mq.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mq[0] ^ 32'hDEAD_0000;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0000_0000;
            end
        end
    end

    // Scoreboard monitor: compare each entry decode accepts
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_entry: got id_pc 0x%08h id_instr 0x%08h, expected none",
                             id_pc, id_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_instr", id_instr, e.instr);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the PC register reaches val, then stop granting
    task automatic wait_pc_then_stop(input logic [31:0] val);
        for (int i = 0; i < 40; i++) begin
            if (pc_r == val) break;
            step(1);
        end
        imem_gnt = 1'b0;
        check("wait_pc", pc_r, val);
    endtask

    task automatic drain_check();
        id_ready = 1'b1;
        step(8);
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_gnt = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        mem_hold = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    initial begin : main
        int g0;
        rst = 1'b1;
        imem_gnt = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0000_0000;
        pc_load = 1'b0;
        pc_load_val = 32'h0000_0000;
        mem_hold = 1'b0;

        // Reset state
        step(2);
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
        step(1);
        rst = 1'b0;

        // Streaming from 0x0
        exp_q.push_back({32'h0000_0000, 32'hDEAD_0000});
        exp_q.push_back({32'h0000_0004, 32'hDEAD_0004});
        exp_q.push_back({32'h0000_0008, 32'hDEAD_0008});
        exp_q.push_back({32'h0000_000C, 32'hDEAD_000C});
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        wait_pc_then_stop(32'h0000_0010);
        drain_check();

        // Backpressure: two grants fill the credits, head held
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'hDEAD_0000});
        exp_q.push_back({32'h0000_0004, 32'hDEAD_0004});
        exp_q.push_back({32'h0000_0008, 32'hDEAD_0008});
        g0 = grant_cnt;
        imem_gnt = 1'b1;
        step(8);
        check("bp_grants", 32'(grant_cnt - g0), 32'd2);
        @(negedge clk);
        check("bp_imem_req", 32'(imem_req), 32'd0);
        check("bp_id_valid", 32'(id_valid), 32'd1);
        check("bp_id_pc", id_pc, 32'h0000_0000);
        @(posedge clk); #1;
        id_ready = 1'b1;
        @(posedge clk); #1;
        id_ready = 1'b0;
        g0 = grant_cnt;
        step(5);
        check("bp_one_more_grant", 32'(grant_cnt - g0), 32'd1);
        imem_gnt = 1'b0;
        drain_check();

        // Redirect with two requests outstanding
        do_reset();
        mem_hold = 1'b1;
        id_ready = 1'b1;
        g0 = grant_cnt;
        imem_gnt = 1'b1;
        step(4);
        check("rd_grants", 32'(grant_cnt - g0), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check("rd_pc_en", 32'(pc_en), 32'd1);
        check("rd_next_pc", next_pc, 32'h0000_0100);
        check("rd_imem_req", 32'(imem_req), 32'd0);
        exp_q.push_back({32'h0000_0100, 32'hDEAD_0100});
        step(1);
        redirect_valid = 1'b0;
        mem_hold = 1'b0;
        wait_pc_then_stop(32'h0000_0104);
        drain_check();

        // Redirect in the same cycle as a response
        do_reset();
        mem_hold = 1'b1;
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        step(4);
        mem_hold = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("rdv_next_pc", next_pc, 32'h0000_0200);
        check("rdv_pc_en", 32'(pc_en), 32'd1);
        exp_q.push_back({32'h0000_0200, 32'hDEAD_0200});
        step(1);
        redirect_valid = 1'b0;
        wait_pc_then_stop(32'h0000_0204);
        drain_check();

        // PC wrap-around
        do_reset();
        id_ready = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 32'hFFFF_FFFC;
        step(1);
        pc_load = 1'b0;
        exp_q.push_back({32'hFFFF_FFFC, 32'h2152_FFFC});
        exp_q.push_back({32'h0000_0000, 32'hDEAD_0000});
        imem_gnt = 1'b1;
        @(negedge clk);
        check("wrap_imem_req", 32'(imem_req), 32'd1);
        check("wrap_pc_en", 32'(pc_en), 32'd1);
        check("wrap_next_pc", next_pc, 32'h0000_0000);
        step(1);
        wait_pc_then_stop(32'h0000_0004);
        drain_check();

        // Reset mid-stream with two requests outstanding
        do_reset();
        mem_hold = 1'b1;
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        step(4);
        rst = 1'b1;
        imem_gnt = 1'b0;
        @(negedge clk);
        check("mid_rst_imem_req", 32'(imem_req), 32'd0);
        check("mid_rst_id_valid", 32'(id_valid), 32'd0);
        check("mid_rst_pc_en", 32'(pc_en), 32'd0);
        step(1);
        rst = 1'b0;
        mem_hold = 1'b0;
        step(4);
        @(negedge clk);
        check("late_rsp_ignored", 32'(id_valid), 32'd0);
        check("restart_pc", pc_r, 32'h0000_0000);
        exp_q.push_back({32'h0000_0000, 32'hDEAD_0000});
        step(1);
        imem_gnt = 1'b1;
        wait_pc_then_stop(32'h0000_0004);
        drain_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
